fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the 9-bit instruction decoder. It owns the program counter, drives the synchronous instruction ROM, and presents one instruction per cycle to decode together with its PC. It also applies branch redirects from execute, honours pipeline stalls, detects the halt instruction, and keeps saturating cycle and instruction counters for performance reporting.

## Interface
- PC_W, 10: program counter and ROM address width.
- HALT_INSTR, 9'h1FF: instruction encoding that terminates execution.
- CNT_W, 16: width of the performance counters.

- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse; begins execution at PC 0; honoured only in IDLE and HALT.
- stall  in  1  holds the current instruction; PC does not advance.
- branch_taken  in  1  execute redirect, qualified with instr_valid & !stall.
- branch_target  in  PC_W  absolute redirect address.
- imem_addr  out  PC_W  ROM read address; combinational; the ROM registers it.
- imem_rdata  in  9  ROM data for the address presented in the previous cycle.
- instr  out  9  instruction to the decoder; equals imem_rdata in RUN.
- instr_valid  out  1  instr/pc are meaningful.
- pc  out  PC_W  address of instr.
- done  out  1  high while in HALT.
- fault  out  1  sticky PC-overflow flag; cleared by start.
- cycle_count  out  CNT_W  cycles spent in PRIME and RUN; saturating.
- instr_count  out  CNT_W  retired instructions; saturating.

## Operation
- States are IDLE, PRIME, RUN and HALT.
- **IDLE**
  - imem_addr = 0; instr_valid = 0.
  - start moves to PRIME and clears pc, fault and both counters.
- **PRIME**
  - imem_addr = pc_q (0).
  - Always moves to RUN on the next edge.
- **RUN**
  - instr_valid = 1; instr = imem_rdata; pc = pc_q.
  - next address priority:
    - stall gives pc_q.
    - else halt gives pc_q.
    - else branch_taken gives branch_target.
    - else pc_q+1.
  - imem_addr = next; pc_q <= next.
- **Halt**
  - Detected when instr == HALT_INSTR and !stall.
  - Goes to HALT; the halt instruction is not counted.
  - branch_taken is ignored on a halt cycle.
- **Retire**
  - An instruction retires when instr_valid & !stall & !halt; instr_count increments on retire.
- **Overflow**
  - Occurs when pc_q is all ones and the next address is pc_q+1 (no stall, branch or halt).
  - Goes to HALT with fault <= 1; the instruction at that cycle still retires.
- **HALT**
  - done = 1; instr_valid = 0; imem_addr = pc_q.
  - start behaves as in IDLE (restart at PC 0, counters and fault cleared).
- start is ignored in PRIME and RUN.
- Counters stick at all ones and never wrap.
- branch_target is used unmodified; no range check is applied.

## Timing
- Reset values:
  - state IDLE; pc 0; imem_addr 0.
  - instr_valid 0; done 0; fault 0.
  - cycle_count 0; instr_count 0.
  - instr equals imem_rdata but is don't-care while invalid.
- Start latency: start high at edge E0 puts PRIME in cycle 1; instr_valid=1 with pc=0 in cycle 2 (2 cycles).
- Throughput: 1 instruction/cycle when not stalled.
- Branch penalty: 0. The target address is driven in the branch's own cycle, and the target instruction is valid on the next cycle.
- Stall: imem_addr re-presents pc_q, so instr and pc are stable for the whole stall; branch_taken is sampled only on the cycle stall drops.
- Halt: done rises the cycle after the halt instruction is presented.
- reset_n low mid-RUN forces IDLE immediately (async), with all outputs at reset values.

## Structure
- Package fetch_pkg holds:
  - enum fetch_state_t {IDLE, PRIME, RUN, HALT};
  - DEFAULT_HALT_INSTR = 9'h1FF;
  - DEFAULT_CNT_W = 16.
- Sub-module sat_counter (parameter W; inputs clk, reset_n, clr, inc; output count) is instantiated twice, for cycle_count and instr_count.
- Next-PC mux and state register live in fetch_unit.

## Test plan
- ROM mem[0..3] = 9'h080, 9'h0C1, 9'h102, 9'h1FF; pulse start -> instr_valid first at cycle 2 with pc 0; pcs 0,1,2 in cycles 2–4; done in cycle 6; instr_count=3, cycle_count=4.
- Branch: branch_taken=1, target=5 at pc 1 -> next valid pc is 5 with no bubble; pc 2 never appears.
- Stall 3 cycles at pc 2 with branch_taken=1 asserted throughout -> pc 2 held 4 cycles; redirect taken only on the unstalled cycle; instr_count increments once for pc 2.
- PC_W=3, no halt in ROM -> pc runs 0..7, then HALT with fault=1, instr_count=8; a new start clears fault and counters and restarts at pc 0.
- Assert reset_n low while in RUN at pc 4 -> outputs return to reset values asynchronously; after release the block stays in IDLE until start.
- Drive instr_count to all ones with CNT_W=4 (a 20-instruction loop via branch) -> count saturates at 15.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [8:0] DEFAULT_HALT_INSTR = 9'h1FF;
  localparam int         DEFAULT_CNT_W      = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM, applies
// redirects and stalls, detects halt and keeps performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int         PC_W       = 10,
  parameter logic [8:0] HALT_INSTR = DEFAULT_HALT_INSTR,
  parameter int         CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_rdata,
  output logic [8:0]       instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic            run;
  logic            halt_hit;
  logic            overflow;
  logic            retire;
  logic            restart;
  logic            cycle_inc;
  logic [PC_W-1:0] next_pc;

  always_comb begin
    run      = (state_q == RUN);
    halt_hit = run && !stall && (imem_rdata == HALT_INSTR);
    retire   = run && !stall && !halt_hit;
    overflow = retire && !branch_taken && (pc_q == '1);
    restart  = start && ((state_q == IDLE) || (state_q == HALT));
    // The halt-detect cycle does no useful work, so it is left out of the cycle count.
    cycle_inc = (state_q == PRIME) || (run && !halt_hit);

    if (stall || halt_hit) begin
      next_pc = pc_q;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_q + PC_W'(1);
    end

    case (state_q)
      PRIME:   imem_addr = pc_q;
      RUN:     imem_addr = next_pc;
      HALT:    imem_addr = pc_q;
      default: imem_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = PRIME;
          pc_d    = '0;
          fault_d = 1'b0;
        end
      end
      PRIME: state_d = RUN;
      RUN: begin
        if (halt_hit) begin
          state_d = HALT;
        end else if (overflow) begin
          // PC is left on the faulting address rather than wrapping.
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          pc_d = next_pc;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
    done_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .inc     (cycle_inc),
    .count   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .inc     (retire),
    .count   (instr_count)
  );

  assign instr       = imem_rdata;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench: stimulus queues expected {pc, instr}; monitors pop on instr_valid.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Default-size instance
  logic        m_start, m_stall, m_br;
  logic [9:0]  m_tgt, m_addr, m_pc;
  logic [8:0]  m_rdata, m_instr;
  logic        m_valid, m_done, m_fault;
  logic [15:0] m_cyc, m_icnt;

  // Small instance: 3-bit PC, 4-bit counters
  logic        s_start, s_stall, s_br;
  logic [2:0]  s_tgt, s_addr, s_pc;
  logic [8:0]  s_rdata, s_instr;
  logic        s_valid, s_done, s_fault;
  logic [3:0]  s_cyc, s_icnt;

  logic [8:0] rom_m [0:1023];
  logic [8:0] rom_s [0:7];

  always @(posedge clk) m_rdata <= rom_m[m_addr];
  always @(posedge clk) s_rdata <= rom_s[s_addr];

  fetch_unit u_main (
    .clk(clk), .reset_n(reset_n), .start(m_start), .stall(m_stall),
    .branch_taken(m_br), .branch_target(m_tgt), .imem_addr(m_addr),
    .imem_rdata(m_rdata), .instr(m_instr), .instr_valid(m_valid), .pc(m_pc),
    .done(m_done), .fault(m_fault), .cycle_count(m_cyc), .instr_count(m_icnt)
  );

  fetch_unit #(.PC_W(3), .CNT_W(4)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .stall(s_stall),
    .branch_taken(s_br), .branch_target(s_tgt), .imem_addr(s_addr),
    .imem_rdata(s_rdata), .instr(s_instr), .instr_valid(s_valid), .pc(s_pc),
    .done(s_done), .fault(s_fault), .cycle_count(s_cyc), .instr_count(s_icnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_m [$];
  int exp_s [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitors: every valid presentation must match the next queued entry
  always @(negedge clk) begin
    logic [31:0] got;
    int e;
    if (m_valid === 1'b1) begin
      checks++;
      got = {13'd0, m_pc, m_instr};
      if (exp_m.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected: got pc %0d instr %h with nothing expected", m_pc, m_instr);
      end else begin
        e = exp_m.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL main_fetch: got pc %0d instr %h expected pc %0d instr %h",
                   m_pc, m_instr, e >> 9, e & 32'h1FF);
        end else begin
          $display("ok   main_fetch pc %0d instr %h", m_pc, m_instr);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] got;
    int e;
    if (s_valid === 1'b1) begin
      checks++;
      got = {20'd0, s_pc, s_instr};
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected: got pc %0d instr %h with nothing expected", s_pc, s_instr);
      end else begin
        e = exp_s.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL small_fetch: got pc %0d instr %h expected pc %0d instr %h",
                   s_pc, s_instr, e >> 9, e & 32'h1FF);
        end else begin
          $display("ok   small_fetch pc %0d instr %h", s_pc, s_instr);
        end
      end
    end
  end

  task automatic push_m(input int p, input int ins);
    exp_m.push_back((p << 9) | ins);
  endtask

  task automatic push_s(input int p, input int ins);
    exp_s.push_back((p << 9) | ins);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Start high over edge E0; returns at the negedge of cycle 1 (PRIME)
  task automatic pulse_m();
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    cyc = 1;
  endtask

  task automatic pulse_s();
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_start = 0; m_stall = 0; m_br = 0; m_tgt = '0;
    s_start = 0; s_stall = 0; s_br = 0; s_tgt = '0;
    for (int i = 0; i < 1024; i++) rom_m[i] = 9'h010 + 9'(i & 15);
    for (int i = 0; i < 8; i++) rom_s[i] = 9'h020 + 9'(i);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    check("rst_valid", m_valid, 0);
    check("rst_pc", m_pc, 0);
    check("rst_addr", m_addr, 0);
    check("rst_done", m_done, 0);
    check("rst_fault", m_fault, 0);
    check("rst_counts", {m_cyc, m_icnt}, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", m_valid, 0);

    // Straight-line program ending in halt
    rom_m[0] = 9'h080; rom_m[1] = 9'h0C1; rom_m[2] = 9'h102; rom_m[3] = 9'h1FF;
    push_m(0, 9'h080); push_m(1, 9'h0C1); push_m(2, 9'h102); push_m(3, 9'h1FF);
    pulse_m();
    check("prime_valid", m_valid, 0);
    check("prime_addr", m_addr, 0);
    repeat (4) step();
    check("t1_done_c5", m_done, 0);
    step();
    check("t1_done_c6", m_done, 1);
    check("t1_valid_c6", m_valid, 0);
    check("t1_icnt", m_icnt, 3);
    check("t1_ccnt", m_cyc, 4);
    check("t1_fault", m_fault, 0);
    check("t1_queue", exp_m.size(), 0);

    // Zero-penalty branch from pc 1 to 5
    for (int i = 0; i < 16; i++) rom_m[i] = 9'h010 + 9'(i);
    rom_m[6] = 9'h1FF;
    push_m(0, 9'h010); push_m(1, 9'h011); push_m(5, 9'h015); push_m(6, 9'h1FF);
    pulse_m();
    step();
    step(); m_br = 1'b1; m_tgt = 10'd5;
    #1 check("t2_branch_addr", m_addr, 5);
    step(); m_br = 1'b0;
    step();
    step();
    check("t2_done", m_done, 1);
    check("t2_icnt", m_icnt, 3);
    check("t2_ccnt", m_cyc, 4);
    check("t2_queue", exp_m.size(), 0);

    // Stall at pc 2 with branch held; start pulse in RUN must be ignored
    push_m(0, 9'h010); push_m(1, 9'h011);
    for (int i = 0; i < 4; i++) push_m(2, 9'h012);
    push_m(4, 9'h014); push_m(5, 9'h015); push_m(6, 9'h1FF);
    pulse_m();
    step(); m_start = 1'b1;
    step(); m_start = 1'b0;
    step(); m_stall = 1'b1; m_br = 1'b1; m_tgt = 10'd4;
    check("t3_icnt_c4", m_icnt, 2);
    step();
    step();
    check("t3_icnt_c6", m_icnt, 2);
    step(); m_stall = 1'b0;
    #1 check("t3_redirect_addr", m_addr, 4);
    step(); m_br = 1'b0;
    check("t3_icnt_c8", m_icnt, 3);
    step();
    step();
    step();
    check("t3_done", m_done, 1);
    check("t3_icnt", m_icnt, 5);
    check("t3_ccnt", m_cyc, 9);
    check("t3_queue", exp_m.size(), 0);

    // Asynchronous reset mid-RUN at pc 4
    for (int i = 0; i < 4; i++) push_m(i, 9'h010 + i);
    pulse_m();
    repeat (4) step();
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("t4_valid", m_valid, 0);
    check("t4_pc", m_pc, 0);
    check("t4_addr", m_addr, 0);
    check("t4_done_fault", {m_done, m_fault}, 0);
    check("t4_counts", {m_cyc, m_icnt}, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_stay_idle", {m_valid, m_done}, 0);
    check("t4_idle_addr", m_addr, 0);
    check("t4_queue", exp_m.size(), 0);

    // PC overflow on the 3-bit instance, then restart clears fault and counters
    for (int i = 0; i < 8; i++) push_s(i, 9'h020 + i);
    pulse_s();
    repeat (9) step();
    check("t5_done", s_done, 1);
    check("t5_fault", s_fault, 1);
    check("t5_icnt", s_icnt, 8);
    check("t5_ccnt", s_cyc, 9);
    for (int i = 0; i < 8; i++) push_s(i, 9'h020 + i);
    pulse_s();
    check("t5_restart_fault", s_fault, 0);
    check("t5_restart_counts", {s_cyc, s_icnt}, 0);
    check("t5_restart_done", s_done, 0);
    repeat (9) step();
    check("t5_refault", s_fault, 1);
    check("t5_queue", exp_s.size(), 0);

    // 20-instruction loop saturates the 4-bit counters
    rom_s[4] = 9'h1FF;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 4; i++) push_s(i, 9'h020 + i);
    push_s(4, 9'h1FF);
    pulse_s();
    for (int c = 2; c <= 22; c++) begin
      step();
      s_br = (c == 5) || (c == 9) || (c == 13) || (c == 17);
      s_tgt = 3'd0;
      if (c == 12) check("t6_icnt_mid", s_icnt, 10);
    end
    step();
    s_br = 1'b0;
    check("t6_done", s_done, 1);
    check("t6_icnt_sat", s_icnt, 15);
    check("t6_ccnt_sat", s_cyc, 15);
    check("t6_fault", s_fault, 0);
    check("t6_queue", exp_s.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
